// File: rtl/sys_counter_bank_pkg.sv
// Shared constants for sys_counter_bank: counter indices, write-target encoding
// and the 32-bit half-select helper.
package SysCounterConsts;

  localparam int unsigned CNT_CYCLE    = 0;
  localparam int unsigned CNT_TIME     = 1;
  localparam int unsigned CNT_INSTRET  = 2;
  localparam int unsigned CNT_HPM_BASE = 3;

  typedef enum logic [1:0] {
    WT_COUNTER  = 2'd0,
    WT_INHIBIT  = 2'd1,
    WT_MTIMECMP = 2'd2,
    WT_RSVD     = 2'd3
  } wtarget_e;

  // Callers zero-extend their CNT_WIDTH value to 64 bits, so the upper half
  // of a narrower counter reads back zero-filled.
  function automatic logic [31:0] half_sel(input logic [63:0] val, input logic upper);
    return upper ? val[63:32] : val[31:0];
  endfunction

endpackage

// File: rtl/sys_counter_bank_cell.sv
// One CNT_WIDTH-bit counter with increment and 32-bit halfword write;
// a write replaces one half and suppresses that cycle's increment.
module sys_counter_cell
  import SysCounterConsts::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 we,
  input  logic                 wupper,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (we) begin
      if (wupper) value_d[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
      else        value_d[31:0]           = wdata;
    end else if (inc) begin
      value_d = value_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sys_counter_bank.sv
// Cycle/time/instret/hpm counter bank with inhibit mask and mtimecmp timer irq.
// Optional COUNTER_SNAPSHOT_EN: lower-half read snapshots the upper half.
module sys_counter_bank
  import SysCounterConsts::*;
#(
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned NUM_HPM        = 4,
  parameter int unsigned CYCLE_PER_TICK = 128
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instret_en,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic [4:0]                           csr_sel,
  input  logic                                 csr_upper,
  input  logic                                 csr_re,
  output logic [31:0]                          csr_rdata,
  input  logic                                 csr_we,
  input  logic [1:0]                           csr_wtarget,
  input  logic [31:0]                          csr_wdata,
  output logic                                 timer_irq
);

  localparam int unsigned NUM_CNT = CNT_HPM_BASE + NUM_HPM;
  localparam int unsigned PS_W    = (CYCLE_PER_TICK > 1) ? $clog2(CYCLE_PER_TICK) : 1;

  wtarget_e             wt;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic                 tick;
  logic [NUM_CNT-1:0]   inh_q, inh_d;
  logic [NUM_CNT-1:0]   inc_vec, cnt_we;
  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] sel_val;
  logic [31:0]          rd_val;

  always_comb begin
    wt   = wtarget_e'(csr_wtarget);
    tick = (ps_q == PS_W'(CYCLE_PER_TICK - 1));
    ps_d = tick ? '0 : ps_q + PS_W'(1);
  end

  always_comb begin
    inc_vec              = '0;
    inc_vec[CNT_CYCLE]   = ~inh_q[CNT_CYCLE];
    inc_vec[CNT_TIME]    = tick & ~inh_q[CNT_TIME];
    inc_vec[CNT_INSTRET] = instret_en & ~inh_q[CNT_INSTRET];
    for (int unsigned j = 0; j < NUM_HPM; j++)
      inc_vec[CNT_HPM_BASE+j] = hpm_event[j] & ~inh_q[CNT_HPM_BASE+j];
    cnt_we  = '0;
    sel_val = '0;
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      cnt_we[k] = csr_we && (wt == WT_COUNTER) && (csr_sel == 5'(k));
      if (csr_sel == 5'(k)) sel_val = cnt[k];
    end
  end

  always_comb begin
    inh_d = inh_q;
    cmp_d = cmp_q;
    if (csr_we && wt == WT_INHIBIT) begin
      inh_d           = csr_wdata[NUM_CNT-1:0];
      inh_d[CNT_TIME] = 1'b0;
    end
    if (csr_we && wt == WT_MTIMECMP) begin
      if (csr_upper) cmp_d[CNT_WIDTH-1:32] = csr_wdata[CNT_WIDTH-33:0];
      else           cmp_d[31:0]           = csr_wdata;
    end
    irq_d = (cnt[CNT_TIME] >= cmp_q);
  end

`ifdef COUNTER_SNAPSHOT_EN
  logic        snap_vld_q, snap_vld_d;
  logic [4:0]  snap_sel_q, snap_sel_d;
  logic [31:0] snap_hi_q,  snap_hi_d;

  always_comb begin
    snap_vld_d = snap_vld_q;
    snap_sel_d = snap_sel_q;
    snap_hi_d  = snap_hi_q;
    rd_val     = half_sel(64'(sel_val), csr_upper);
    if (csr_re) begin
      if (!csr_upper) begin
        snap_vld_d = 1'b1;
        snap_sel_d = csr_sel;
        snap_hi_d  = half_sel(64'(sel_val), 1'b1);
      end else if (snap_vld_q && snap_sel_q == csr_sel) begin
        rd_val = snap_hi_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_vld_q <= 1'b0;
      snap_sel_q <= '0;
      snap_hi_q  <= '0;
    end else begin
      snap_vld_q <= snap_vld_d;
      snap_sel_q <= snap_sel_d;
      snap_hi_q  <= snap_hi_d;
    end
  end
`else
  always_comb rd_val = half_sel(64'(sel_val), csr_upper);
`endif

  always_comb rdata_d = csr_re ? rd_val : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= '0;
      inh_q   <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ps_q    <= ps_d;
      inh_q   <= inh_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sys_counter_cell #(.CNT_WIDTH(CNT_WIDTH)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc_vec[g]),
      .we     (cnt_we[g]),
      .wupper (csr_upper),
      .wdata  (csr_wdata),
      .value  (cnt[g])
    );
  end

  if (NUM_HPM == 0) begin : g_no_hpm
    logic unused_hpm;
    assign unused_hpm = ^hpm_event;
  end

  assign csr_rdata = rdata_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_sys_counter_bank.sv
// Directed bench for sys_counter_bank (default parameters, 128 cycles per tick).
module tb_sys_counter_bank;

  logic        clk = 1'b0;
  logic        rst, instret_en, csr_upper, csr_re, csr_we, timer_irq;
  logic [3:0]  hpm_event;
  logic [4:0]  csr_sel;
  logic [1:0]  csr_wtarget;
  logic [31:0] csr_wdata, csr_rdata;

  int n_total = 0;
  int n_bad   = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;

  sys_counter_bank #(.CNT_WIDTH(64), .NUM_HPM(4), .CYCLE_PER_TICK(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .instret_en  (instret_en),
    .hpm_event   (hpm_event),
    .csr_sel     (csr_sel),
    .csr_upper   (csr_upper),
    .csr_re      (csr_re),
    .csr_rdata   (csr_rdata),
    .csr_we      (csr_we),
    .csr_wtarget (csr_wtarget),
    .csr_wdata   (csr_wdata),
    .timer_irq   (timer_irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input logic chk);
    rst = 1'b1;
    idle(2);
    if (chk) begin
      check_eq("rst_rdata", csr_rdata, 32'h0);
      check_eq("rst_irq", {31'b0, timer_irq}, 32'h0);
    end
    rst    = 1'b0;
    edge_n = 0;
  endtask

  task automatic rd(input logic [4:0] sel, input logic upper, input logic [31:0] exp, input string tag);
    csr_re = 1'b1; csr_sel = sel; csr_upper = upper;
    cyc();
    csr_re = 1'b0;
    check_eq(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] tgt, input logic [4:0] sel, input logic upper, input logic [31:0] data);
    csr_we = 1'b1; csr_wtarget = tgt; csr_sel = sel; csr_upper = upper; csr_wdata = data;
    cyc();
    csr_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instret_en = 1'b0; hpm_event = '0; csr_sel = '0; csr_upper = 1'b0;
    csr_re = 1'b0; csr_we = 1'b0; csr_wtarget = '0; csr_wdata = '0;

    // free-running counters after reset
    do_reset(1'b1);
    idle(300);
    rd(5'd0, 1'b0, 32'd300, "cycle_lo_300");
    rd(5'd1, 1'b0, 32'd2,   "time_lo_2");
    rd(5'd2, 1'b0, 32'd0,   "instret_lo_0");
    rd(5'd0, 1'b1, 32'd0,   "cycle_hi_0");
    check_eq("irq_idle", {31'b0, timer_irq}, 32'h0);

    // carry from lower to upper half, then full wrap
    do_reset(1'b0);
    wr(2'd0, 5'd0, 1'b0, 32'hFFFF_FFFF);
    idle(1);
    rd(5'd0, 1'b0, 32'h0, "carry_lo");
    rd(5'd0, 1'b1, 32'h1, "carry_hi");
    wr(2'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
    wr(2'd0, 5'd0, 1'b0, 32'hFFFF_FFFF);
    idle(1);
    rd(5'd0, 1'b0, 32'h0, "wrap_lo");
    rd(5'd0, 1'b1, 32'h0, "wrap_hi");

    // inhibit cycle and instret
    do_reset(1'b0);
    wr(2'd1, 5'd0, 1'b0, 32'h5);
    wr(2'd0, 5'd0, 1'b1, 32'h0);
    wr(2'd0, 5'd0, 1'b0, 32'h1000);
    instret_en = 1'b1; idle(20); instret_en = 1'b0;
    rd(5'd0, 1'b0, 32'h1000, "inh_cycle_frozen");
    rd(5'd2, 1'b0, 32'd0,    "inh_instret_frozen");
    wr(2'd1, 5'd0, 1'b0, 32'h0);
    instret_en = 1'b1; idle(20); instret_en = 1'b0;
    rd(5'd0, 1'b0, 32'h1014, "uninh_cycle");
    rd(5'd2, 1'b0, 32'd20,   "uninh_instret");

    // time cannot be inhibited; a time write keeps the prescaler phase
    do_reset(1'b0);
    wr(2'd1, 5'd0, 1'b0, 32'hF);
    idle(198);
    rd(5'd1, 1'b0, 32'd1, "time_not_inhibited");
    rd(5'd0, 1'b0, 32'd1, "cycle_inhibited");
    wr(2'd0, 5'd1, 1'b0, 32'h50);
    idle(53);
    rd(5'd1, 1'b0, 32'h50, "time_wr_before_tick");
    rd(5'd1, 1'b0, 32'h51, "time_wr_ps_kept");

    // mtimecmp and timer_irq
    do_reset(1'b0);
    wr(2'd2, 5'd0, 1'b1, 32'h0);
    wr(2'd2, 5'd0, 1'b0, 32'd3);
    idle(382);
    check_eq("irq_time_eq3_edge", {31'b0, timer_irq}, 32'h0);
    cyc();
    check_eq("irq_rise", {31'b0, timer_irq}, 32'h1);
    wr(2'd2, 5'd0, 1'b0, 32'd10);
    check_eq("irq_hold", {31'b0, timer_irq}, 32'h1);
    cyc();
    check_eq("irq_fall", {31'b0, timer_irq}, 32'h0);

    // hpm write beats event; read/write collision; out of range
    do_reset(1'b0);
    hpm_event = 4'b0010;
    wr(2'd0, 5'd4, 1'b0, 32'h100);
    hpm_event = '0;
    rd(5'd4, 1'b0, 32'h100, "hpm_write_wins");
    hpm_event = 4'b0010; cyc(); hpm_event = '0;
    rd(5'd4, 1'b0, 32'h101, "hpm_event_inc");
    csr_re = 1'b1; csr_we = 1'b1; csr_wtarget = 2'd0; csr_sel = 5'd4; csr_upper = 1'b0;
    csr_wdata = 32'h200;
    cyc();
    csr_re = 1'b0; csr_we = 1'b0;
    check_eq("rw_same_old", csr_rdata, 32'h101);
    idle(2);
    check_eq("rdata_held", csr_rdata, 32'h101);
    rd(5'd4, 1'b0, 32'h200, "rw_same_new");
    wr(2'd0, 5'd7, 1'b0, 32'hAB);
    rd(5'd7, 1'b0, 32'h0, "oor_sel7");
    rd(5'd31, 1'b1, 32'h0, "oor_sel31_hi");
    wr(2'd3, 5'd4, 1'b0, 32'h55);
    rd(5'd4, 1'b0, 32'h200, "wt_rsvd_ignored");

    // upper read after lower read across a carry
    do_reset(1'b0);
    wr(2'd0, 5'd0, 1'b1, 32'h0);
    wr(2'd0, 5'd0, 1'b0, 32'hFFFF_FFF0);
    rd(5'd0, 1'b0, 32'hFFFF_FFF0, "snap_lo");
    idle(32);
`ifdef COUNTER_SNAPSHOT_EN
    rd(5'd0, 1'b1, 32'h0, "snap_hi_shadow");
`else
    rd(5'd0, 1'b1, 32'h1, "snap_hi_live");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
